wb_trace_monitor: RTL and testbench

Synthesisable successor to the simulation-only LM32 data-bus transaction printer. It passively snoops NCH Wishbone master ports, such as lm32d and lm32i. Each completed transfer is filtered by address and channel, then written as a timestamped record into an on-chip trace FIFO. Software drains the FIFO through a Wishbone slave register port mapped on the system bus.

---
 rtl/wb_trace_pkg.sv | 40 ++++
 rtl/wb_trace_monitor_if.sv | 34 +++
 rtl/trace_fifo.sv | 51 +++++
 rtl/wb_trace_monitor.sv | 165 ++++++++++++++++
 tb/tb_wb_trace_monitor.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_trace_pkg.sv
// Shared constants for the Wishbone trace monitor: register map, CTRL/STATUS
// bit positions and the trace record layout {ch, we, ts, adr}.
package wb_trace_pkg;

  // Word index as decoded from wb_adr_i[4:2]
  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_STATUS    = 3'd1;
  localparam logic [2:0] REG_MATCH     = 3'd2;
  localparam logic [2:0] REG_MASK      = 3'd3;
  localparam logic [2:0] REG_HEAD_ADR  = 3'd4;
  localparam logic [2:0] REG_HEAD_INFO = 3'd5;
  localparam logic [2:0] REG_POP       = 3'd6;
  localparam logic [2:0] REG_DROP      = 3'd7;

  localparam int CTRL_EN_LSB     = 0;
  localparam int CTRL_EN_W       = 4;
  localparam int CTRL_MODE_BIT   = 4;
  localparam int CTRL_THRESH_LSB = 8;
  localparam int CTRL_THRESH_W   = 8;

  localparam int STATUS_COUNT_LSB = 0;
  localparam int STATUS_COUNT_W   = 9;
  localparam int STATUS_EMPTY_BIT = 16;
  localparam int STATUS_FULL_BIT  = 17;
  localparam int STATUS_OVF_BIT   = 31;

  localparam int INFO_WE_BIT = 29;
  localparam int INFO_CH_LSB = 30;

  localparam int CH_W       = 2;
  localparam int ADR_W      = 32;
  localparam int REC_BASE_W = CH_W + 1 + ADR_W;  // add TS_W for the full record

  typedef struct packed {
    logic [CTRL_THRESH_W-1:0] thresh;
    logic                     mode;
    logic [CTRL_EN_W-1:0]     en;
  } ctrl_t;

endpackage

// File: rtl/wb_trace_monitor_if.sv
// Bundles the snooped master buses and the register slave port of the monitor.
// Slave handshake: an access starts when wb_stb_i & wb_cyc_i are high while
// wb_ack_o is low; wb_ack_o answers for exactly one cycle on the next cycle.
interface wb_trace_monitor_if #(
  parameter int NCH = 2
);
  logic [NCH-1:0]    mon_cyc;
  logic [NCH-1:0]    mon_stb;
  logic [NCH-1:0]    mon_ack;
  logic [NCH-1:0]    mon_we;
  logic [32*NCH-1:0] mon_adr;

  logic              wb_stb_i;
  logic              wb_cyc_i;
  logic              wb_we_i;
  logic [31:0]       wb_adr_i;
  logic [31:0]       wb_dat_i;
  logic [3:0]        wb_sel_i;
  logic [31:0]       wb_dat_o;
  logic              wb_ack_o;
  logic              irq;

  modport master (
    output mon_cyc, mon_stb, mon_ack, mon_we, mon_adr,
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o, irq
  );

  modport slave (
    input  mon_cyc, mon_stb, mon_ack, mon_we, mon_adr,
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o, irq
  );
endinterface

// File: rtl/trace_fifo.sv
// Power-of-two FIFO with an optional overwrite-oldest mode when full.
// A read on an empty FIFO is ignored; read-and-write when full never overwrites.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  input  logic                   overwrite,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_rd;
  logic          do_wr;
  logic          drop_old;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_rd    = rd_en & ~empty;
  assign do_wr    = wr_en & (~full | do_rd | overwrite);
  // Overwrite: the write lands on the oldest slot, so the read side skips it.
  assign drop_old = do_wr & full & ~do_rd;
  assign rd_data  = mem[rp];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd | drop_old) rp <= rp + 1'b1;
      if (do_wr & ~(do_rd | drop_old)) count <= count + 1'b1;
      else if (~do_wr & do_rd)         count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/wb_trace_monitor.sv
// Snoops NCH Wishbone masters, filters completed transfers by address and
// channel, and stores timestamped records in a FIFO drained via a slave port.
module wb_trace_monitor
  import wb_trace_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  wb_trace_monitor_if.slave bus
);
  localparam int RW = REC_BASE_W + TS_W;
  localparam int CW = $clog2(DEPTH) + 1;

  ctrl_t            ctrl;
  logic [31:0]      match;
  logic [31:0]      mask;
  logic [15:0]      drop;
  logic             ovf;
  logic [TS_W-1:0]  ts;
  logic             ack;
  logic [31:0]      dat;

  logic [NCH-1:0]   hit;
  logic             any_hit;
  logic [CH_W-1:0]  sel;
  logic [2:0]       n_hits;
  logic [31:0]      sel_adr;
  logic             sel_we;

  logic [RW-1:0]    head;
  logic [CW-1:0]    count;
  logic [8:0]       count9;
  logic             full;
  logic             empty;

  logic             acc;
  logic             wr;
  logic [2:0]       idx;
  logic             pop;
  logic             do_pop;
  logic             discard;
  logic             set_ovf;
  logic [2:0]       drop_inc;
  logic [16:0]      drop_sum;
  logic [15:0]      drop_sat;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign unused_bits = ^{bus.wb_adr_i[31:5], bus.wb_adr_i[1:0], bus.wb_sel_i};

  // Descending scan so the lowest-index hit is the one left in sel.
  always_comb begin
    hit     = '0;
    sel     = '0;
    n_hits  = '0;
    sel_adr = '0;
    sel_we  = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      hit[i] = bus.mon_cyc[i] & bus.mon_stb[i] & bus.mon_ack[i] & ctrl.en[i] &
               ((bus.mon_adr[32*i +: 32] & mask) == (match & mask));
      if (hit[i]) begin
        sel     = CH_W'(i);
        sel_adr = bus.mon_adr[32*i +: 32];
        sel_we  = bus.mon_we[i];
        n_hits  = n_hits + 3'd1;
      end
    end
  end

  assign any_hit = |hit;
  assign acc     = bus.wb_stb_i & bus.wb_cyc_i & ~ack;
  assign wr      = acc & bus.wb_we_i;
  assign idx     = bus.wb_adr_i[4:2];
  assign pop     = wr && (idx == REG_POP);
  assign do_pop  = pop & ~empty;
  assign count9  = 9'(count);

  assign set_ovf  = any_hit & full & ~do_pop;
  assign discard  = set_ovf & ~ctrl.mode;
  assign drop_inc = (any_hit ? n_hits - 3'd1 : 3'd0) + {2'b00, discard};
  assign drop_sum = {1'b0, drop} + 17'(drop_inc);
  assign drop_sat = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  trace_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (any_hit),
    .wr_data   ({sel, sel_we, ts, sel_adr}),
    .rd_en     (pop),
    .overwrite (ctrl.mode),
    .rd_data   (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    rdata = '0;
    case (idx)
      REG_CTRL:   rdata = {16'd0, ctrl.thresh, 3'd0, ctrl.mode, ctrl.en};
      REG_STATUS: begin
        rdata[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count9;
        rdata[STATUS_EMPTY_BIT] = empty;
        rdata[STATUS_FULL_BIT]  = full;
        rdata[STATUS_OVF_BIT]   = ovf;
      end
      REG_MATCH:  rdata = match;
      REG_MASK:   rdata = mask;
      REG_HEAD_ADR: begin
        if (!empty) rdata = head[ADR_W-1:0];
      end
      REG_HEAD_INFO: begin
        if (!empty) begin
          rdata[TS_W-1:0]               = head[ADR_W +: TS_W];
          rdata[INFO_WE_BIT]            = head[ADR_W + TS_W];
          rdata[INFO_CH_LSB +: CH_W]    = head[RW-1 -: CH_W];
        end
      end
      REG_DROP:   rdata = {16'd0, drop};
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl  <= '0;
      match <= '0;
      mask  <= '0;
      drop  <= '0;
      ovf   <= 1'b0;
      ts    <= '0;
      ack   <= 1'b0;
      dat   <= '0;
    end else begin
      ack <= acc;
      dat <= (acc & ~bus.wb_we_i) ? rdata : '0;
      if (wr) begin
        case (idx)
          REG_CTRL: begin
            ctrl.en     <= bus.wb_dat_i[CTRL_EN_LSB +: CTRL_EN_W];
            ctrl.mode   <= bus.wb_dat_i[CTRL_MODE_BIT];
            ctrl.thresh <= bus.wb_dat_i[CTRL_THRESH_LSB +: CTRL_THRESH_W];
          end
          REG_MATCH: match <= bus.wb_dat_i;
          REG_MASK:  mask  <= bus.wb_dat_i;
          default:   ;
        endcase
      end
      // A loss in the same cycle as a clear keeps the flag set.
      if (set_ovf) ovf <= 1'b1;
      else if (wr && idx == REG_STATUS && bus.wb_dat_i[STATUS_OVF_BIT]) ovf <= 1'b0;
      if (wr && idx == REG_DROP) drop <= '0;
      else                       drop <= drop_sat;
      if (|ctrl.en) ts <= ts + 1'b1;
    end
  end

  // thresh=0 means the interrupt is disabled rather than permanently asserted.
  assign bus.irq      = (ctrl.thresh != 8'd0) && (count9 >= {1'b0, ctrl.thresh});
  assign bus.wb_ack_o = ack;
  assign bus.wb_dat_o = dat;
endmodule

// File: tb/tb_wb_trace_monitor.sv
// Bench for wb_trace_monitor: directed test-plan scenarios followed by random
// snoop and register traffic, checked against a queue-based reference model.
module tb_wb_trace_monitor;
  localparam int NCH   = 2;
  localparam int DEPTH = 16;
  localparam int TS_W  = 16;
  localparam int W     = 32;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_trace_monitor_if #(.NCH(NCH)) bus ();

  wb_trace_monitor #(.NCH(NCH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  string        name_q[$];

  typedef struct {
    logic [1:0]      ch;
    logic            we;
    logic [TS_W-1:0] ts;
    logic [31:0]     adr;
  } rec_t;

  rec_t        m_q[$];
  logic [3:0]  m_en;
  logic        m_mode;
  logic [7:0]  m_thresh;
  logic [31:0] m_match;
  logic [31:0] m_mask;
  int          m_drop;
  logic        m_ovf;
  int          m_ts;
  logic        m_ack;
  logic        ovr;
  logic [31:0] ovr_val;
  string reg_name[8] = '{"ctrl", "status", "match", "mask",
                         "head_adr", "head_info", "pop", "drop"};

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_en = '0; m_mode = 1'b0; m_thresh = '0;
    m_match = '0; m_mask = '0;
    m_drop = 0; m_ovf = 1'b0; m_ts = 0; m_ack = 1'b0;
    ovr = 1'b0; ovr_val = '0;
  endtask

  function automatic logic m_irq();
    return (m_thresh != 0) && (m_q.size() >= int'(m_thresh));
  endfunction

  function automatic logic [31:0] model_read(logic [2:0] idx);
    logic [31:0] v;
    v = '0;
    case (idx)
      3'd0: v = {16'd0, m_thresh, 3'd0, m_mode, m_en};
      3'd1: begin
        v[8:0] = 9'(m_q.size());
        v[16]  = (m_q.size() == 0);
        v[17]  = (m_q.size() == DEPTH);
        v[31]  = m_ovf;
      end
      3'd2: v = m_match;
      3'd3: v = m_mask;
      3'd4: if (m_q.size() > 0) v = m_q[0].adr;
      3'd5: if (m_q.size() > 0) begin
        v[TS_W-1:0] = m_q[0].ts;
        v[29]       = m_q[0].we;
        v[31:30]    = m_q[0].ch;
      end
      3'd7: v = 32'(m_drop);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Applies the effect of the coming clock edge to the model, using the
  // inputs currently driven, and queues any slave response it will produce.
  task automatic model_edge();
    logic        acc;
    logic        wr;
    logic [2:0]  idx;
    logic [31:0] d;
    logic [3:0]  old_en;
    int          hits[$];
    rec_t        r;
    acc = bus.wb_stb_i && bus.wb_cyc_i && !m_ack;
    wr  = acc && bus.wb_we_i;
    idx = bus.wb_adr_i[4:2];
    d   = bus.wb_dat_i;
    if (acc) begin
      if (bus.wb_we_i) begin
        exp_q.push_back('0); name_q.push_back("write_dat");
      end else begin
        exp_q.push_back(ovr ? ovr_val : model_read(idx));
        name_q.push_back(reg_name[idx]);
      end
    end
    ovr = 1'b0;
    for (int ch = 0; ch < NCH; ch++)
      if (bus.mon_cyc[ch] && bus.mon_stb[ch] && bus.mon_ack[ch] && m_en[ch] &&
          ((bus.mon_adr[32*ch +: 32] & m_mask) == (m_match & m_mask)))
        hits.push_back(ch);
    old_en = m_en;
    if (wr && idx == 3'd1 && d[31]) m_ovf = 1'b0;
    if (wr && idx == 3'd6 && m_q.size() > 0) void'(m_q.pop_front());
    if (hits.size() > 0) begin
      r.ch  = 2'(hits[0]);
      r.we  = bus.mon_we[hits[0]];
      r.ts  = TS_W'(m_ts);
      r.adr = bus.mon_adr[32*hits[0] +: 32];
      if (m_q.size() == DEPTH) begin
        m_ovf = 1'b1;
        if (m_mode) begin
          void'(m_q.pop_front());
          m_q.push_back(r);
        end else m_drop++;
      end else m_q.push_back(r);
      m_drop += hits.size() - 1;
      if (m_drop > 65535) m_drop = 65535;
    end
    if (wr) begin
      case (idx)
        3'd0: begin m_en = d[3:0]; m_mode = d[4]; m_thresh = d[15:8]; end
        3'd2: m_match = d;
        3'd3: m_mask = d;
        3'd7: m_drop = 0;
        default: ;
      endcase
    end
    if (old_en != 0) m_ts = (m_ts + 1) % (1 << TS_W);
    m_ack = acc;
  endtask

  // driver tasks
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("irq", 32'(bus.irq), 32'(m_irq()));
  endtask

  task automatic idle_bus();
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = $urandom(); bus.wb_dat_i = $urandom(); bus.wb_sel_i = 4'($urandom());
  endtask

  task automatic drive_access(logic we, logic [2:0] idx, logic [31:0] d);
    logic [31:0] a;
    a = $urandom();
    a[4:2] = idx;
    bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = a; bus.wb_dat_i = d; bus.wb_sel_i = 4'($urandom());
  endtask

  task automatic clear_mon();
    bus.mon_cyc = '0; bus.mon_stb = '0; bus.mon_ack = '0; bus.mon_we = '0;
    for (int ch = 0; ch < NCH; ch++) bus.mon_adr[32*ch +: 32] = $urandom();
  endtask

  task automatic set_hit(int ch, logic [31:0] a, logic we);
    bus.mon_cyc[ch] = 1'b1; bus.mon_stb[ch] = 1'b1; bus.mon_ack[ch] = 1'b1;
    bus.mon_we[ch] = we; bus.mon_adr[32*ch +: 32] = a;
  endtask

  task automatic hit_one(int ch, logic [31:0] a, logic we);
    set_hit(ch, a, we);
    tick();
    clear_mon();
  endtask

  task automatic bus_write(logic [2:0] idx, logic [31:0] d);
    drive_access(1'b1, idx, d);
    tick();
    idle_bus();
    tick();
  endtask

  task automatic bus_read(logic [2:0] idx);
    drive_access(1'b0, idx, '0);
    tick();
    idle_bus();
    tick();
  endtask

  task automatic bus_read_exp(logic [2:0] idx, logic [31:0] e);
    ovr = 1'b1;
    ovr_val = e;
    bus_read(idx);
  endtask

  function automatic logic [31:0] pick_adr();
    case ($urandom_range(0, 3))
      0: return 32'h8000_0010;
      1: return 32'h0000_0010;
      2: return 32'h8000_001F;
      default: return $urandom();
    endcase
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (bus.wb_ack_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack got ack=1 expected no response pending");
        end else check(name_q.pop_front(), bus.wb_dat_o, exp_q.pop_front());
      end else check("idle_dat", bus.wb_dat_o, '0);
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL timeout got no finish expected finish within budget");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    clear_mon();
    idle_bus();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_ack", 32'(bus.wb_ack_o), '0);
    check("reset_irq", 32'(bus.irq), '0);
    check("reset_dat", bus.wb_dat_o, '0);
    for (int i = 0; i < 8; i++) bus_read(3'(i));

    // basic capture
    bus_write(3'd0, 32'h1);
    while (m_ts != 5) tick();
    hit_one(0, 32'h0000_0400, 1'b1);
    bus_read_exp(3'd4, 32'h0000_0400);
    bus_read_exp(3'd5, 32'h2000_0005);
    bus_read_exp(3'd1, 32'h0000_0001);
    bus_write(3'd6, '0);
    bus_read_exp(3'd1, 32'h0001_0000);

    // address filter
    bus_write(3'd2, 32'h8000_0000);
    bus_write(3'd3, 32'hF000_0000);
    hit_one(0, 32'h8000_0010, 1'b0);
    hit_one(0, 32'h0000_0010, 1'b0);
    bus_read_exp(3'd1, 32'h0000_0001);
    bus_read_exp(3'd4, 32'h8000_0010);
    bus_write(3'd6, '0);

    // simultaneous hits
    bus_write(3'd3, 32'h0);
    bus_write(3'd0, 32'h3);
    set_hit(0, 32'h100, 1'b0);
    set_hit(1, 32'h200, 1'b1);
    tick();
    clear_mon();
    bus_read_exp(3'd7, 32'h1);
    bus_read_exp(3'd4, 32'h100);
    bus_read(3'd5);
    bus_write(3'd6, '0);
    bus_write(3'd7, '0);

    // stop mode
    bus_write(3'd0, 32'h01);
    for (int i = 0; i < 17; i++) hit_one(0, 32'(i), 1'b0);
    bus_read_exp(3'd1, 32'h8002_0010);
    bus_read_exp(3'd4, 32'h0);
    bus_read_exp(3'd7, 32'h1);
    bus_write(3'd0, 32'h0);
    for (int i = 0; i < 16; i++) bus_write(3'd6, '0);
    bus_write(3'd1, 32'h8000_0000);
    bus_write(3'd7, '0);
    bus_read_exp(3'd1, 32'h0001_0000);

    // ring mode
    bus_write(3'd0, 32'h11);
    for (int i = 0; i < 17; i++) hit_one(0, 32'(i), 1'b0);
    bus_read_exp(3'd1, 32'h8002_0010);
    bus_read_exp(3'd4, 32'h1);
    bus_read_exp(3'd7, 32'h0);
    bus_write(3'd1, 32'h8000_0000);
    bus_read_exp(3'd1, 32'h0002_0010);

    // pop with capture at full (ring) and at count 3
    drive_access(1'b1, 3'd6, '0);
    set_hit(0, 32'h55, 1'b0);
    tick();
    clear_mon(); idle_bus(); tick();
    bus_read_exp(3'd1, 32'h0002_0010);
    bus_read_exp(3'd4, 32'h2);
    for (int i = 0; i < 13; i++) bus_write(3'd6, '0);
    drive_access(1'b1, 3'd6, '0);
    set_hit(0, 32'h66, 1'b0);
    tick();
    clear_mon(); idle_bus(); tick();
    bus_read_exp(3'd1, 32'h0000_0003);
    bus_read_exp(3'd4, 32'h10);

    // reset mid-operation with a slave strobe pending
    bus_write(3'd0, 32'h101);
    check("irq_before_reset", 32'(bus.irq), 32'h1);
    drive_access(1'b0, 3'd1, '0);
    #2 reset = 1'b1;
    @(negedge clk);
    check("reset_mid_ack", 32'(bus.wb_ack_o), '0);
    check("reset_mid_irq", 32'(bus.irq), '0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle_bus();
    model_reset();
    bus_read_exp(3'd0, 32'h0);
    bus_read_exp(3'd1, 32'h0001_0000);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      int r;
      logic [31:0] d;
      clear_mon();
      for (int ch = 0; ch < NCH; ch++)
        if ($urandom_range(0, 2) == 0) begin
          bus.mon_cyc[ch] = 1'b1;
          bus.mon_stb[ch] = ($urandom_range(0, 5) != 0);
          bus.mon_ack[ch] = ($urandom_range(0, 5) != 0);
          bus.mon_we[ch]  = 1'($urandom());
          bus.mon_adr[32*ch +: 32] = pick_adr();
        end
      if (bus.wb_stb_i) idle_bus();
      else if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 99);
        d = $urandom();
        if (r < 40) drive_access(1'b0, 3'($urandom_range(0, 7)), '0);
        else if (r < 58) drive_access(1'b1, 3'd6, d);
        else if (r < 66) begin
          d = '0;
          d[3:0]  = 4'($urandom_range(0, 15));
          d[4]    = 1'($urandom());
          d[15:8] = 8'($urandom_range(0, 17));
          drive_access(1'b1, 3'd0, d);
        end
        else if (r < 70) drive_access(1'b1, 3'd2, pick_adr());
        else if (r < 74) begin
          case ($urandom_range(0, 3))
            0: d = 32'h0;
            1: d = 32'hF000_0000;
            2: d = 32'hFFFF_FFFF;
            default: d = 32'h0000_000F;
          endcase
          drive_access(1'b1, 3'd3, d);
        end
        else if (r < 78) drive_access(1'b1, 3'd1, d);
        else if (r < 80) drive_access(1'b1, 3'd7, d);
        else drive_access(1'b0, 3'($urandom_range(0, 7)), '0);
      end
      tick();
    end
    clear_mon();
    idle_bus();
    repeat (3) tick();
    check("pending_responses", 32'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
